// File: rtl/brick_field_ctrl.sv
// Brick-field store for the breakout engine: per-brick hit points, a 2-cycle render lookup,
// and a query/erase handshake for the ball logic with live-brick count and level-clear pulse.
module brick_field_ctrl #(
    parameter int COLS        = 16,
    parameter int ROWS        = 8,
    parameter int CELL_W_LOG2 = 5,
    parameter int CELL_H_LOG2 = 3,
    parameter int ORIGIN_X    = 64,
    parameter int ORIGIN_Y    = 64,
    parameter int HP_W        = 2,
    parameter int INIT_HP     = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              init,
    input  logic [9:0]                        hcount,
    input  logic [9:0]                        vcount,
    output logic                              pix_on,
    output logic [2:0]                        pix_rgb,
    input  logic                              q_valid,
    output logic                              q_ready,
    input  logic [9:0]                        q_x,
    input  logic [9:0]                        q_y,
    output logic                              r_valid,
    output logic                              r_hit,
    output logic                              r_cleared,
    output logic [$clog2(COLS*ROWS+1)-1:0]    bricks_left,
    output logic                              all_clear,
    output logic                              busy
);

    localparam int NCELLS = COLS * ROWS;
    localparam int IDX_W  = $clog2(NCELLS);
    localparam int CNT_W  = $clog2(NCELLS + 1);
    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + (COLS << CELL_W_LOG2));
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + (ROWS << CELL_H_LOG2));
    localparam logic [9:0]  X_MASK = 10'((1 << CELL_W_LOG2) - 1);
    localparam logic [9:0]  Y_MASK = 10'((1 << CELL_H_LOG2) - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCELLS - 1);
    localparam logic [HP_W-1:0]  HP_LOAD  = HP_W'(INIT_HP);
    localparam logic [HP_W-1:0]  HP_ZERO  = {HP_W{1'b0}};
    localparam logic [HP_W-1:0]  HP_ONE   = HP_W'(1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Bounds are compared on 11 bits before any subtraction, so coordinates left of the grid never alias in.
    function automatic logic in_grid(input logic [9:0] x, input logic [9:0] y);
        return ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
               ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input logic [9:0] x, input logic [9:0] y);
        logic [9:0] col;
        logic [9:0] row;
        col = (x - 10'(ORIGIN_X)) >> CELL_W_LOG2;
        row = (y - 10'(ORIGIN_Y)) >> CELL_H_LOG2;
        return IDX_W'(row * 10'(COLS) + col);
    endfunction

    function automatic logic off_mortar(input logic [9:0] x, input logic [9:0] y);
        return (((x - 10'(ORIGIN_X)) & X_MASK) != 10'd0) &&
               (((y - 10'(ORIGIN_Y)) & Y_MASK) != 10'd0);
    endfunction

    function automatic logic [2:0] row_colour(input logic [9:0] y);
        logic [9:0] row;
        row = (y - 10'(ORIGIN_Y)) >> CELL_H_LOG2;
        return 3'(row % 10'd7) + 3'd1;
    endfunction

    state_t state_r, next_state_s;

    logic [HP_W-1:0]  hp_mem_r [NCELLS];
    logic [IDX_W-1:0] init_idx_r;
    logic [9:0]       qx_r, qy_r;
    logic             wr_en_r;
    logic [IDX_W-1:0] wr_idx_r;
    logic [HP_W-1:0]  wr_hp_r;
    logic             busy_r, q_ready_r, r_valid_r, r_hit_r, r_cleared_r, all_clear_r;
    logic [CNT_W-1:0] bricks_left_r;

    logic             rnd_in_r, rnd_edge_r;
    logic [IDX_W-1:0] rnd_idx_r;
    logic [2:0]       rnd_rgb_r;
    logic [HP_W-1:0]  rnd_hp_s;
    logic             pix_on_s, pix_on_r;
    logic [2:0]       pix_rgb_s, pix_rgb_r;

    logic             q_in_s, q_hit_s, q_clr_s;
    logic [IDX_W-1:0] q_idx_s;
    logic [HP_W-1:0]  q_hp_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; init overrides every state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init) begin
                    next_state_s = ST_INIT;
                end else if (init_idx_r == LAST_IDX) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (init) begin
                    next_state_s = ST_INIT;
                end else if (q_valid) begin
                    next_state_s = ST_READ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (init) begin
                    next_state_s = ST_INIT;
                end else begin
                    next_state_s = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (init) begin
                    next_state_s = ST_INIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: next_state_s = ST_INIT;
        endcase
    end

    // Query lookup of the latched coordinate during READ.
    always_comb begin
        q_in_s  = in_grid(qx_r, qy_r);
        q_idx_s = cell_idx(qx_r, qy_r);
        q_hp_s  = hp_mem_r[q_idx_s];
        q_hit_s = q_in_s && (q_hp_s != HP_ZERO);
        q_clr_s = q_hit_s && (q_hp_s == HP_ONE);
    end

    // Control datapath: init sweep, query latch, response and brick count.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_idx_r    <= {IDX_W{1'b0}};
            busy_r        <= 1'b1;
            q_ready_r     <= 1'b0;
            r_valid_r     <= 1'b0;
            r_hit_r       <= 1'b0;
            r_cleared_r   <= 1'b0;
            all_clear_r   <= 1'b0;
            bricks_left_r <= {CNT_W{1'b0}};
            qx_r          <= 10'd0;
            qy_r          <= 10'd0;
            wr_en_r       <= 1'b0;
            wr_idx_r      <= {IDX_W{1'b0}};
            wr_hp_r       <= HP_ZERO;
        end else begin
            busy_r      <= (next_state_s == ST_INIT);
            q_ready_r   <= (next_state_s == ST_IDLE);
            r_valid_r   <= 1'b0;
            all_clear_r <= 1'b0;
            if (init) begin
                init_idx_r    <= {IDX_W{1'b0}};
                bricks_left_r <= {CNT_W{1'b0}};
                wr_en_r       <= 1'b0;
            end else begin
                case (state_r)
                    ST_INIT: begin
                        if (init_idx_r == LAST_IDX) begin
                            init_idx_r    <= {IDX_W{1'b0}};
                            bricks_left_r <= CNT_W'(NCELLS);
                        end else begin
                            init_idx_r <= init_idx_r + IDX_W'(1);
                        end
                    end
                    ST_IDLE: begin
                        if (q_valid) begin
                            qx_r <= q_x;
                            qy_r <= q_y;
                        end
                    end
                    ST_READ: begin
                        r_valid_r   <= 1'b1;
                        r_hit_r     <= q_hit_s;
                        r_cleared_r <= q_clr_s;
                        wr_en_r     <= q_hit_s;
                        wr_idx_r    <= q_idx_s;
                        wr_hp_r     <= q_hp_s - HP_ONE;
                        if (q_clr_s && (bricks_left_r != {CNT_W{1'b0}})) begin
                            bricks_left_r <= bricks_left_r - CNT_W'(1);
                            all_clear_r   <= (bricks_left_r == CNT_W'(1));
                        end
                    end
                    ST_WRITE: wr_en_r <= 1'b0;
                    default:  wr_en_r <= 1'b0;
                endcase
            end
        end
    end

    // Hit-point array: init sweep loads, WRITE stores the decremented value.
    always_ff @(posedge clk) begin
        if (!reset && !init && (state_r == ST_INIT)) begin
            hp_mem_r[init_idx_r] <= HP_LOAD;
        end else if (!reset && !init && (state_r == ST_WRITE) && wr_en_r) begin
            hp_mem_r[wr_idx_r] <= wr_hp_r;
        end
    end

    // Render stage 0: register cell address and geometry of the current pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            rnd_in_r   <= 1'b0;
            rnd_edge_r <= 1'b0;
            rnd_idx_r  <= {IDX_W{1'b0}};
            rnd_rgb_r  <= 3'd0;
        end else begin
            rnd_in_r   <= in_grid(hcount, vcount);
            rnd_edge_r <= off_mortar(hcount, vcount);
            rnd_idx_r  <= cell_idx(hcount, vcount);
            rnd_rgb_r  <= row_colour(vcount);
        end
    end

    // Render stage 1 decode: multi-hit bricks show white.
    always_comb begin
        rnd_hp_s  = hp_mem_r[rnd_idx_r];
        pix_on_s  = 1'b0;
        pix_rgb_s = 3'd0;
        if (rnd_in_r && rnd_edge_r && (rnd_hp_s != HP_ZERO)) begin
            pix_on_s = 1'b1;
            if (rnd_hp_s > HP_ONE) begin
                pix_rgb_s = 3'b111;
            end else begin
                pix_rgb_s = rnd_rgb_r;
            end
        end else begin
            pix_on_s  = 1'b0;
            pix_rgb_s = 3'd0;
        end
    end

    // Render stage 1 output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_on_r  <= 1'b0;
            pix_rgb_r <= 3'd0;
        end else begin
            pix_on_r  <= pix_on_s;
            pix_rgb_r <= pix_rgb_s;
        end
    end

    assign pix_on      = pix_on_r;
    assign pix_rgb     = pix_rgb_r;
    assign q_ready     = q_ready_r;
    assign r_valid     = r_valid_r;
    assign r_hit       = r_hit_r;
    assign r_cleared   = r_cleared_r;
    assign bricks_left = bricks_left_r;
    assign all_clear   = all_clear_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_brick_field_ctrl.sv
// Directed bench for brick_field_ctrl: one single-hit instance (a) and one two-hit instance (b).
module tb_brick_field_ctrl;

    logic       clk = 1'b0;
    logic       reset, init;
    logic [9:0] hcount, vcount, q_x, q_y;
    logic       q_valid_a, q_valid_b;

    logic       a_pix_on, a_q_ready, a_r_valid, a_r_hit, a_r_cleared, a_all_clear, a_busy;
    logic [2:0] a_pix_rgb;
    logic [7:0] a_bricks_left;
    logic       b_pix_on, b_q_ready, b_r_valid, b_r_hit, b_r_cleared, b_all_clear, b_busy;
    logic [2:0] b_pix_rgb;
    logic [7:0] b_bricks_left;

    int checks = 0;
    int errors = 0;
    int ac_pulses = 0;

    brick_field_ctrl dut_a (
        .clk(clk), .reset(reset), .init(init), .hcount(hcount), .vcount(vcount),
        .pix_on(a_pix_on), .pix_rgb(a_pix_rgb), .q_valid(q_valid_a), .q_ready(a_q_ready),
        .q_x(q_x), .q_y(q_y), .r_valid(a_r_valid), .r_hit(a_r_hit), .r_cleared(a_r_cleared),
        .bricks_left(a_bricks_left), .all_clear(a_all_clear), .busy(a_busy)
    );

    brick_field_ctrl #(.INIT_HP(2)) dut_b (
        .clk(clk), .reset(reset), .init(init), .hcount(hcount), .vcount(vcount),
        .pix_on(b_pix_on), .pix_rgb(b_pix_rgb), .q_valid(q_valid_b), .q_ready(b_q_ready),
        .q_x(q_x), .q_y(q_y), .r_valid(b_r_valid), .r_hit(b_r_hit), .r_cleared(b_r_cleared),
        .bricks_left(b_bricks_left), .all_clear(b_all_clear), .busy(b_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_all_clear) ac_pulses++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic query(input int which, input logic [9:0] x, input logic [9:0] y,
                         output logic hit, output logic clr, output logic ac, output logic [7:0] left);
        int n;
        n = 0;
        while (!(which != 0 ? b_q_ready : a_q_ready) && n < 20) begin
            tick();
            n++;
        end
        check_val("q_ready", which != 0 ? b_q_ready : a_q_ready, 1);
        q_x = x;
        q_y = y;
        if (which != 0) q_valid_b = 1'b1; else q_valid_a = 1'b1;
        tick();
        q_valid_a = 1'b0;
        q_valid_b = 1'b0;
        check_val("r_valid_early", which != 0 ? b_r_valid : a_r_valid, 0);
        tick();
        check_val("r_valid", which != 0 ? b_r_valid : a_r_valid, 1);
        hit  = which != 0 ? b_r_hit     : a_r_hit;
        clr  = which != 0 ? b_r_cleared : a_r_cleared;
        ac   = which != 0 ? b_all_clear : a_all_clear;
        left = which != 0 ? b_bricks_left : a_bricks_left;
        tick();
        check_val("r_valid_len", which != 0 ? b_r_valid : a_r_valid, 0);
    endtask

    task automatic render(input int which, input logic [9:0] h, input logic [9:0] v,
                          output logic on, output logic [2:0] rgb);
        hcount = h;
        vcount = v;
        tick();
        tick();
        on  = which != 0 ? b_pix_on  : a_pix_on;
        rgb = which != 0 ? b_pix_rgb : a_pix_rgb;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       hit, clr, ac, on;
        logic [7:0] left;
        logic [2:0] rgb;
        logic [9:0] mx [3];
        logic [9:0] my [3];
        int         hits;

        mx = '{10'd63, 10'd576, 10'd133};
        my = '{10'd75, 10'd75,  10'd128};
        reset = 1'b1; init = 1'b0; q_valid_a = 1'b0; q_valid_b = 1'b0;
        hcount = 10'd0; vcount = 10'd0; q_x = 10'd0; q_y = 10'd0;
        repeat (3) tick();
        check_val("rst_busy", a_busy, 1);
        check_val("rst_q_ready", a_q_ready, 0);
        check_val("rst_r_valid", a_r_valid, 0);
        check_val("rst_bricks", a_bricks_left, 0);
        check_val("rst_pix_on", a_pix_on, 0);
        check_val("rst_pix_rgb", a_pix_rgb, 0);
        check_val("rst_all_clear", a_all_clear, 0);

        reset = 1'b0;
        repeat (127) tick();
        check_val("init_busy_127", a_busy, 1);
        tick();
        check_val("init_busy_128", a_busy, 0);
        check_val("init_bricks", a_bricks_left, 128);
        check_val("init_q_ready", a_q_ready, 1);
        check_val("init_bricks_b", b_bricks_left, 128);

        query(0, 10'd133, 10'd75, hit, clr, ac, left);
        check_val("hit1", hit, 1);
        check_val("clr1", clr, 1);
        check_val("left1", left, 127);
        check_val("ac1", ac, 0);
        query(0, 10'd133, 10'd75, hit, clr, ac, left);
        check_val("hit_again", hit, 0);
        check_val("left_again", left, 127);
        for (int i = 0; i < 3; i++) begin
            query(0, mx[i], my[i], hit, clr, ac, left);
            check_val("miss_hit", hit, 0);
            check_val("miss_left", left, 127);
        end

        render(0, 10'd97, 10'd72, on, rgb);
        check_val("mortar_on", on, 0);
        check_val("mortar_rgb", rgb, 0);
        render(0, 10'd98, 10'd73, on, rgb);
        check_val("brick_on", on, 1);
        check_val("brick_rgb", rgb, 2);
        render(0, 10'd98, 10'd121, on, rgb);
        check_val("row7_rgb", rgb, 1);
        render(0, 10'd133, 10'd75, on, rgb);
        check_val("gone_on", on, 0);

        render(1, 10'd133, 10'd75, on, rgb);
        check_val("b_on", on, 1);
        check_val("b_rgb_hp2", rgb, 7);
        query(1, 10'd133, 10'd75, hit, clr, ac, left);
        check_val("b_hit1", hit, 1);
        check_val("b_clr1", clr, 0);
        check_val("b_left1", left, 128);
        render(1, 10'd133, 10'd75, on, rgb);
        check_val("b_rgb_hp1", rgb, 2);
        query(1, 10'd133, 10'd75, hit, clr, ac, left);
        check_val("b_hit2", hit, 1);
        check_val("b_clr2", clr, 1);
        check_val("b_left2", left, 127);

        q_x = 10'd200; q_y = 10'd80; q_valid_a = 1'b1;
        tick();
        q_valid_a = 1'b0;
        init = 1'b1;
        tick();
        init = 1'b0;
        check_val("abort_r_valid", a_r_valid, 0);
        check_val("abort_busy", a_busy, 1);
        repeat (127) tick();
        check_val("abort_r_valid_late", a_r_valid, 0);
        check_val("reinit_busy_127", a_busy, 1);
        tick();
        check_val("reinit_busy", a_busy, 0);
        check_val("reinit_bricks", a_bricks_left, 128);
        query(0, 10'd133, 10'd75, hit, clr, ac, left);
        check_val("reinit_hit", hit, 1);
        check_val("reinit_left", left, 127);

        ac_pulses = 0;
        hits = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 16; c++) begin
                query(0, 10'(64 + c * 32 + 5), 10'(64 + r * 8 + 3), hit, clr, ac, left);
                if (hit) hits++;
                if (r == 7 && c == 15) begin
                    check_val("final_ac", ac, 1);
                    check_val("final_left", left, 0);
                end
            end
        end
        check_val("clear_hits", hits, 127);
        check_val("ac_pulses", ac_pulses, 1);
        query(0, 10'd70, 10'd70, hit, clr, ac, left);
        check_val("empty_hit", hit, 0);
        check_val("empty_left", left, 0);
        check_val("empty_ac", ac, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
